// File: rtl/controle_pc_pkg.sv
// Shared definitions for the PC sequencer: FSM states, the default reset PC
// and the branch-type encoding, which does not depend on the opcode.
package controle_pc_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RESOLVE = 1'b1
    } state_t;

    typedef enum logic {
        BT_BEQ = 1'b0,
        BT_BNE = 1'b1
    } branch_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/contador_saturante.sv
// Event counter that stops at all-ones instead of wrapping back to zero.
module contador_saturante #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] valor
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] r_valor;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valor <= '0;
        end else if (inc && (r_valor != MAX)) begin
            r_valor <= r_valor + ONE;
        end
    end

    assign valor = r_valor;

endmodule

// File: rtl/controle_pc.sv
// PC sequencer: advances the PC, redirects jumps in one cycle and holds the PC
// while a conditional branch waits for the ULA zero flag.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_RUN     | normal sequencing: pc+4, jump redirect or branch issue
//   ST_RESOLVE | branch issued, pc held until zero_valid arrives
module controle_pc
    import controle_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             control_beq,
    input  logic             control_bne,
    input  logic             control_jump,
    input  logic [15:0]      branch_offset,
    input  logic [25:0]      jump_target,
    input  logic             zero,
    input  logic             zero_valid,
    output logic [31:0]      pc,
    output logic             pc_write,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_target;
    logic [31:0] w_target_nxt;
    branch_t     r_btype;
    branch_t     w_btype_nxt;
    logic        r_pc_write;
    logic        w_pc_write_nxt;
    logic        r_flush;
    logic        w_flush_nxt;
    logic        w_inc_branch;
    logic        w_inc_taken;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_pc;
    logic        w_taken;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_offset = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_offset;
    assign w_jump_pc   = {w_pc_plus4[31:28], jump_target, 2'b00};
    assign w_taken     = (zero && (r_btype == BT_BEQ)) || (!zero && (r_btype == BT_BNE));

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_target_nxt   = r_target;
        w_btype_nxt    = r_btype;
        w_pc_write_nxt = 1'b0;
        w_flush_nxt    = 1'b0;
        w_inc_branch   = 1'b0;
        w_inc_taken    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    if (control_jump) begin
                        w_pc_nxt       = w_jump_pc;
                        w_pc_write_nxt = 1'b1;
                        w_flush_nxt    = 1'b1;
                    end else if (control_beq || control_bne) begin
                        // BEQ has priority when the decoder flags both
                        w_target_nxt = w_br_target;
                        w_btype_nxt  = control_beq ? BT_BEQ : BT_BNE;
                        w_inc_branch = 1'b1;
                        w_state_nxt  = ST_RESOLVE;
                    end else begin
                        w_pc_nxt       = w_pc_plus4;
                        w_pc_write_nxt = 1'b1;
                    end
                end
            end
            ST_RESOLVE: begin
                if (!stall && zero_valid) begin
                    w_pc_write_nxt = 1'b1;
                    w_state_nxt    = ST_RUN;
                    if (w_taken) begin
                        w_pc_nxt    = r_target;
                        w_flush_nxt = 1'b1;
                        w_inc_taken = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_target   <= '0;
            r_btype    <= BT_BEQ;
            r_pc_write <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_target   <= w_target_nxt;
            r_btype    <= w_btype_nxt;
            r_pc_write <= w_pc_write_nxt;
            r_flush    <= w_flush_nxt;
        end
    end

    contador_saturante #(.W(CNT_W)) u_cnt_branch (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_inc_branch),
        .valor   (branch_count)
    );

    contador_saturante #(.W(CNT_W)) u_cnt_taken (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_inc_taken),
        .valor   (taken_count)
    );

    assign pc       = r_pc;
    assign pc_write = r_pc_write;
    assign flush    = r_flush;
    assign busy     = (r_state == ST_RESOLVE);

endmodule

// File: doc/controle_pc.md
CONTROLE_PC -- requirements
Module: controle_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, the width of the statistics counters.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  holds the sequencer for the current cycle.
REQ-006 control_beq  input  1  BEQ decoded this cycle.
REQ-007 control_bne  input  1  BNE decoded this cycle.
REQ-008 control_jump  input  1  J decoded this cycle.
REQ-009 branch_offset  input  16  signed word offset of the branch.
REQ-010 jump_target  input  26  word target of the jump.
REQ-011 zero  input  1  ULA Zero flag.
REQ-012 zero_valid  input  1  zero is valid for the pending branch.
REQ-013 pc  output  32  current program counter, registered.
REQ-014 pc_write  output  1  registered pulse, high one cycle after every pc change.
REQ-015 flush  output  1  registered pulse, high one cycle after a taken branch or jump redirect.
REQ-016 busy  output  1  high while a branch is waiting to resolve (RESOLVE state).
REQ-017 branch_count  output  CNT_W  number of branches issued, saturating.
REQ-018 taken_count  output  CNT_W  number of branches taken, saturating.

Function
REQ-019 The FSM SHALL have two states: RUN and RESOLVE.
REQ-020 In RUN with stall=1, pc SHALL hold and pc_write/flush SHALL be 0 in the next cycle.
REQ-021 In RUN with stall=0 and no control input, pc SHALL advance to pc+4.
REQ-022 In RUN with stall=0 and control_jump=1, pc SHALL become {pc+4[31:28], jump_target, 2'b00} and flush SHALL pulse; any branch input in that cycle SHALL be ignored.
REQ-023 In RUN with stall=0, control_jump=0 and control_beq or control_bne set, the block SHALL:
  - latch target = pc+4+(sign-extended branch_offset<<2);
  - latch the branch type, with BEQ winning if both are set;
  - increment branch_count;
  - hold pc and enter RESOLVE, with busy=1 from the next cycle.
REQ-024 In RESOLVE with stall=1, the state SHALL hold and zero_valid SHALL be ignored.
REQ-025 In RESOLVE with stall=0 and zero_valid=0, the state SHALL hold with no time limit.
REQ-026 In RESOLVE with stall=0 and zero_valid=1, the block SHALL compute taken=(zero&BEQ)|(~zero&BNE) and then:
  - if taken: pc<=target, flush pulses, taken_count increments;
  - if not taken: pc<=pc+4, no flush;
  - in both cases return to RUN.
REQ-027 Control inputs arriving while in RESOLVE SHALL be ignored.
REQ-028 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-029 Counters SHALL saturate at all-ones and never wrap.
REQ-030 Latency: branch issue to pc update SHALL be 1 cycle plus the cycles until zero_valid; a jump SHALL take 1 cycle.

Reset
REQ-031 While reset_n=0, the block SHALL hold pc=RESET_PC, state=RUN, pc_write=0, flush=0, busy=0 and both counters at 0.
REQ-032 Reset asserted in RESOLVE SHALL discard the pending branch with no flush pulse.
REQ-033 After reset_n deasserts, the first pc advance SHALL occur on the first rising edge with stall=0.

Structure
REQ-034 A shared package SHALL hold:
  - state encoding RUN=1'b0, RESOLVE=1'b1;
  - the RESET_PC default;
  - the opcode-independent branch-type encoding (BT_BEQ, BT_BNE).
REQ-035 The saturating counter SHALL be a sub-module, contador_saturante (parameter W; ports clock, reset_n, inc, valor), instantiated twice.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - Reset, then 3 unstalled cycles -> pc 0,4,8,12; pc_write high each cycle after the first update.
  - At pc=0x100: BEQ, offset=+3; zero_valid with zero=1 two cycles later -> pc=0x110, flush one cycle, branch_count=1, taken_count=1.
  - At pc=0x100: BNE, offset=-1, zero=1 -> not taken, pc=0x104, no flush, taken_count unchanged.
  - At pc=0x2000_0000: jump_target=26'h10, with control_beq also high -> pc=0x2000_0040, flush pulse, branch_count unchanged.
  - pc=0xFFFF_FFFC, no control -> pc=0; reset_n low during RESOLVE -> pc=RESET_PC, busy=0, no flush.
  - Force both counters to 16'hFFFF and issue a taken branch -> both stay 16'hFFFF.
